// File: rtl/ex6_resp_capture.sv
`default_nettype none
// ============================================================================
// ex6_resp_capture : timestamped change-event capture of the ex6 response
// vector into a show-ahead FIFO drained over valid/ready.  Rev 1.0
// ============================================================================
module ex6_resp_capture #(
  parameter int DEPTH       = 8,
  parameter int TS_W        = 12,
  parameter int STOP_ON_OVF = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  input  logic [7:0]                y_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TS_W+7:0]           out_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      overflow,
  output logic [7:0]                drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [7:0]      prev_q, prev_d;
  logic            first_q, first_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  logic [TS_W+7:0] mem_q [DEPTH];

  logic sample, evt, push, pop, drop;

  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q;
    prev_d     = prev_q;
    first_d    = first_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    pop    = (count_q != '0) && out_ready;
    sample = en && (state_q != HALT);
    evt    = sample && (first_q || (y_in != prev_q));
    // A full FIFO still accepts the push when the head leaves on the same edge.
    push   = evt && ((count_q != FULL_CNT) || pop);
    drop   = evt && !push;

    if (sample) ts_d = ts_q + TS_W'(1);
    if (evt) begin
      prev_d  = y_in;
      first_d = 1'b0;
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    case (state_q)
      IDLE:    if (en) state_d = RUN;
      default: state_d = state_q;
    endcase
    if (drop && (STOP_ON_OVF != 0)) state_d = HALT;

    if (clr) begin
      state_d    = IDLE;
      ts_d       = '0;
      prev_d     = '0;
      first_d    = 1'b1;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      prev_q     <= '0;
      first_q    <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      prev_q     <= prev_d;
      first_q    <= first_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is unreset; it is only visible through out_data when count!=0.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= {ts_q, y_in};
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign full      = (count_q == FULL_CNT);
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ex6_resp_capture.sv
`default_nettype none
// ============================================================================
// tb_ex6_resp_capture : scoreboard bench for ex6_resp_capture (two configs).
// Rev 1.0
// ============================================================================
module tb_ex6_resp_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clr_a, en_a, rdy_a, clr_b, en_b, rdy_b;
  logic [7:0]  y_a, y_b;
  logic        valid_a, full_a, ovf_a, valid_b, full_b, ovf_b;
  logic [19:0] data_a;
  logic [11:0] data_b;
  logic [3:0]  count_a;
  logic [2:0]  count_b;
  logic [7:0]  drop_a, drop_b;

  ex6_resp_capture #(.DEPTH(8), .TS_W(12), .STOP_ON_OVF(0)) dut_a (
    .clk(clk), .rst(rst), .clr(clr_a), .en(en_a), .y_in(y_a),
    .out_valid(valid_a), .out_ready(rdy_a), .out_data(data_a),
    .count(count_a), .full(full_a), .overflow(ovf_a), .drop_cnt(drop_a)
  );

  ex6_resp_capture #(.DEPTH(4), .TS_W(4), .STOP_ON_OVF(1)) dut_b (
    .clk(clk), .rst(rst), .clr(clr_b), .en(en_b), .y_in(y_b),
    .out_valid(valid_b), .out_ready(rdy_b), .out_data(data_b),
    .count(count_b), .full(full_b), .overflow(ovf_b), .drop_cnt(drop_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  // Reference model, one slot per DUT (0 = dut_a, 1 = dut_b).
  int m_ts[2], m_prev[2], m_first[2], m_cnt[2], m_ovf[2], m_drop[2], m_halt[2];
  int depth[2]  = '{8, 4};
  int ts_mod[2] = '{4096, 16};
  int stop[2]   = '{0, 1};
  int q0[$];
  int q1[$];

  task automatic model_clear(input int d);
    m_ts[d] = 0; m_prev[d] = 0; m_first[d] = 1; m_cnt[d] = 0;
    m_ovf[d] = 0; m_drop[d] = 0; m_halt[d] = 0;
    if (d == 0) q0.delete(); else q1.delete();
  endtask

  task automatic cycle(input int d, input bit en, input logic [7:0] y, input bit rdy);
    logic [31:0] av, ad, ac, af, ao, adc;
    int  head;
    bit  smp, ev;
    @(negedge clk);
    clr_a = 1'b0; clr_b = 1'b0;
    en_a  = (d == 0) ? en : 1'b0;  y_a = (d == 0) ? y : 8'h00;  rdy_a = (d == 0) ? rdy : 1'b0;
    en_b  = (d == 1) ? en : 1'b0;  y_b = (d == 1) ? y : 8'h00;  rdy_b = (d == 1) ? rdy : 1'b0;
    #1;
    if (d == 0) begin
      av = 32'(valid_a); ad = 32'(data_a); ac = 32'(count_a);
      af = 32'(full_a);  ao = 32'(ovf_a);  adc = 32'(drop_a);
    end else begin
      av = 32'(valid_b); ad = 32'(data_b); ac = 32'(count_b);
      af = 32'(full_b);  ao = 32'(ovf_b);  adc = 32'(drop_b);
    end
    head = 0;
    if (m_cnt[d] != 0) head = (d == 0) ? q0[0] : q1[0];
    check($sformatf("d%0d_count", d),     ac,  32'(m_cnt[d]));
    check($sformatf("d%0d_full", d),      af,  32'(m_cnt[d] == depth[d]));
    check($sformatf("d%0d_overflow", d),  ao,  32'(m_ovf[d]));
    check($sformatf("d%0d_drop_cnt", d),  adc, 32'(m_drop[d]));
    check($sformatf("d%0d_out_valid", d), av,  32'(m_cnt[d] != 0));
    check($sformatf("d%0d_out_data", d),  ad,  32'(head));

    if (rdy && m_cnt[d] != 0) begin
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      m_cnt[d]--;
    end
    smp = en && (m_halt[d] == 0);
    ev  = smp && (m_first[d] != 0 || int'(y) != m_prev[d]);
    if (ev) begin
      m_prev[d]  = int'(y);
      m_first[d] = 0;
      if (m_cnt[d] < depth[d]) begin
        if (d == 0) q0.push_back(m_ts[d] * 256 + int'(y));
        else        q1.push_back(m_ts[d] * 256 + int'(y));
        m_cnt[d]++;
      end else begin
        m_ovf[d] = 1;
        if (m_drop[d] < 255) m_drop[d]++;
        if (stop[d] != 0) m_halt[d] = 1;
      end
    end
    if (smp) m_ts[d] = (m_ts[d] + 1) % ts_mod[d];
    @(posedge clk); #1;
  endtask

  task automatic do_clr(input int d);
    @(negedge clk);
    en_a = 1'b0; rdy_a = 1'b0; en_b = 1'b0; rdy_b = 1'b0;
    clr_a = (d == 0); clr_b = (d == 1);
    @(posedge clk); #1;
    clr_a = 1'b0; clr_b = 1'b0;
    model_clear(d);
  endtask

  initial begin
    rst = 1'b1;
    clr_a = 0; en_a = 0; rdy_a = 0; y_a = 0;
    clr_b = 0; en_b = 0; rdy_b = 0; y_b = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_a), 0);
    check("rst_data",  32'(data_a),  0);
    check("rst_count", 32'(count_a), 0);
    check("rst_full",  32'(full_a),  0);
    check("rst_ovf",   32'(ovf_b),   0);
    check("rst_drop",  32'(drop_b),  0);
    @(negedge clk);
    rst = 1'b0;
    model_clear(0);
    model_clear(1);

    // Held vector produces a single event.
    repeat (3) cycle(0, 1'b1, 8'h1D, 1'b0);
    check("t1_count", 32'(count_a), 1);
    check("t1_head",  32'(data_a),  32'h0001D);
    repeat (2) cycle(0, 1'b0, 8'h00, 1'b1);

    // Timestamps on a change sequence.
    do_clr(0);
    cycle(0, 1'b1, 8'h00, 1'b0);
    cycle(0, 1'b1, 8'h00, 1'b0);
    cycle(0, 1'b1, 8'h0C, 1'b0);
    cycle(0, 1'b1, 8'h03, 1'b0);
    check("t2_count", 32'(count_a), 3);
    repeat (4) cycle(0, 1'b0, 8'h00, 1'b1);

    // Overflow: 10 events into 8 entries.
    do_clr(0);
    for (int i = 0; i < 10; i++) cycle(0, 1'b1, 8'(8'h10 + i), 1'b0);
    check("t3_count", 32'(count_a), 8);
    check("t3_full",  32'(full_a),  1);
    check("t3_ovf",   32'(ovf_a),   1);
    check("t3_drop",  32'(drop_a),  2);
    check("t3_head",  32'(data_a),  32'h00010);
    repeat (9) cycle(0, 1'b0, 8'h00, 1'b1);

    // Push while full with simultaneous pop.
    do_clr(0);
    for (int i = 0; i < 8; i++) cycle(0, 1'b1, 8'(8'h20 + i), 1'b0);
    cycle(0, 1'b1, 8'hAA, 1'b1);
    check("t4_count", 32'(count_a), 8);
    check("t4_drop",  32'(drop_a),  0);
    check("t4_head",  32'(data_a),  32'h00121);
    repeat (9) cycle(0, 1'b0, 8'h00, 1'b1);

    // Stop-on-overflow configuration halts capture.
    do_clr(1);
    for (int i = 0; i < 5; i++) cycle(1, 1'b1, 8'(8'h31 + i), 1'b0);
    check("t5_ovf",  32'(ovf_b),   1);
    check("t5_drop", 32'(drop_b),  1);
    for (int i = 0; i < 3; i++) cycle(1, 1'b1, 8'(8'h40 + i), 1'b0);
    check("t5_halt_count", 32'(count_b), 4);
    for (int i = 0; i < 4; i++) cycle(1, 1'b1, 8'(8'h50 + i), 1'b1);
    cycle(1, 1'b1, 8'h77, 1'b0);
    check("t5_drained", 32'(count_b), 0);
    do_clr(1);
    check("t5_clr_ovf",  32'(ovf_b),  0);
    check("t5_clr_drop", 32'(drop_b), 0);
    cycle(1, 1'b1, 8'h55, 1'b0);
    check("t5_restart", 32'(data_b), 32'h055);
    cycle(1, 1'b0, 8'h00, 1'b1);

    // 4-bit timestamp wrap.
    do_clr(1);
    for (int i = 0; i < 17; i++) begin
      cycle(1, 1'b1, (i % 2 == 0) ? 8'h01 : 8'h02, 1'b1);
      if (i == 15) check("t6_ts15", 32'(data_b), 32'hF02);
    end
    check("t6_wrap", 32'(data_b), 32'h001);
    repeat (2) cycle(1, 1'b0, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
